// File: rtl/trainled_pkg.sv
// Shared types and width helpers for the multi-chain pulse-width LED decoder.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the node FSM state encoding and the clog2-based counter width helper.
package trainled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FWD  = 2'd3
    } node_state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trainled_multi_if.sv
// Pin-level bundle of the LED chains: serial inputs, forwarded outputs and PWM outputs.
// Latency: n/a (wires only). Backpressure: none, the serial protocol is purely timed.
// The master side drives din; the slave side (the decoder) drives dout and led.
interface trainled_multi_if #(
    parameter int NCH  = 2,
    parameter int NLED = 3
);
    logic [NCH-1:0]      din;
    logic [NCH-1:0]      dout;
    logic [NCH*NLED-1:0] led;

    modport master (output din, input dout, input led);
    modport slave  (input din, output dout, output led);
endinterface

// File: rtl/trainled_node.sv
// One daisy-chain node: decodes a pulse-width stream, keeps the first frame, forwards the rest.
// Latency: din to dout 3 clk while forwarding; new duty applies at the PWM wrap after frame timeout.
// Backpressure: none; the stream is consumed at line rate and the outputs are free-running.
module trainled_node
    import trainled_pkg::*;
#(
    parameter int NLED      = 3,
    parameter int PWM_W     = 8,
    parameter int T1_CYC    = 8,
    parameter int MIN_PULSE = 2,
    parameter int IDLE_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [PWM_W-1:0] cnt,
    input  logic             wrap,
    output logic             dout,
    output logic [NLED-1:0]  led
);
    localparam int FRAME_BITS = NLED * PWM_W;
    localparam int LEN_W      = cnt_width(IDLE_CYC);
    localparam int BC_W       = cnt_width(FRAME_BITS);

    logic                  s1, ds, ds_prev;
    logic [LEN_W-1:0]      len;
    logic [BC_W-1:0]       bitcnt;
    logic [FRAME_BITS-1:0] shreg, pending, duty;
    node_state_t           state, state_nxt;
    logic                  rise, fall, low_tmo, shift_en, frame_end;

    assign rise    = ds & ~ds_prev;
    assign fall    = ~ds & ds_prev;
    assign low_tmo = ~ds & ~ds_prev & (len == LEN_W'(IDLE_CYC));

    // len holds how long ds_prev has been at its level, so on a fall it is the pulse width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            ds      <= 1'b0;
            ds_prev <= 1'b0;
            len     <= '0;
        end else begin
            s1      <= din;
            ds      <= s1;
            ds_prev <= ds;
            if (ds != ds_prev)
                len <= LEN_W'(1);
            else if (len != {LEN_W{1'b1}})
                len <= len + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: if (rise) state_nxt = ST_HIGH;
            ST_HIGH: begin
                if (fall) begin
                    state_nxt = ST_LOW;
                    if (len >= LEN_W'(MIN_PULSE)) begin
                        shift_en = 1'b1;
                        if (bitcnt == BC_W'(FRAME_BITS - 1))
                            state_nxt = ST_FWD;
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                end else if (low_tmo) begin
                    frame_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (low_tmo) begin
                    frame_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt  <= '0;
            shreg   <= '0;
            pending <= '0;
            duty    <= '0;
            dout    <= 1'b0;
            led     <= '0;
        end else begin
            if (shift_en) begin
                shreg  <= {shreg[FRAME_BITS-2:0], (len >= LEN_W'(T1_CYC))};
                bitcnt <= bitcnt + 1'b1;
            end
            // Only a complete frame reaches pending; partial frames are dropped here.
            if (frame_end) begin
                if (bitcnt == BC_W'(FRAME_BITS))
                    pending <= shreg;
                bitcnt <= '0;
            end
            if (wrap)
                duty <= pending;
            dout <= (state == ST_FWD) & ds;
            for (int k = 0; k < NLED; k++)
                led[k] <= (cnt < duty[FRAME_BITS-1-k*PWM_W -: PWM_W]);
        end
    end

endmodule

// File: rtl/trainled_multi.sv
// NCH independent LED chain nodes sharing one free-running PWM counter.
// Latency: din to dout 3 clk in forwarding; duty changes only at the counter wrap.
// Backpressure: none; every channel decodes its pin stream at line rate.
module trainled_multi
    import trainled_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int NLED      = 3,
    parameter int PWM_W     = 8,
    parameter int T1_CYC    = 8,
    parameter int MIN_PULSE = 2,
    parameter int IDLE_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    trainled_multi_if.slave  bus
);
    logic [PWM_W-1:0]    cnt;
    logic                wrap;
    logic [NCH-1:0]      dout_w;
    logic [NCH*NLED-1:0] led_w;

    // wrap marks the edge on which cnt goes all-ones -> 0.
    assign wrap = (cnt == {PWM_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_node
        trainled_node #(
            .NLED      (NLED),
            .PWM_W     (PWM_W),
            .T1_CYC    (T1_CYC),
            .MIN_PULSE (MIN_PULSE),
            .IDLE_CYC  (IDLE_CYC)
        ) u_node (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (bus.din[c]),
            .cnt   (cnt),
            .wrap  (wrap),
            .dout  (dout_w[c]),
            .led   (led_w[c*NLED +: NLED])
        );
    end

    assign bus.dout = dout_w;
    assign bus.led  = led_w;

endmodule

// File: tb/tb_trainled_multi.sv
// Directed bench for trainled_multi: frames, forwarding, partial frames, glitches, update timing.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_trainled_multi;
    localparam int NCH  = 2;
    localparam int NLED = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;
    int   on_cnt [NCH*NLED];
    int   fwd_err [NCH];
    logic [NCH-1:0] hist [0:2047];

    trainled_multi_if #(.NCH(NCH), .NLED(NLED)) bus ();

    trainled_multi #(
        .NCH(NCH), .NLED(NLED), .PWM_W(8), .T1_CYC(8), .MIN_PULSE(2), .IDLE_CYC(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Mirrors the PWM counter: cnt == cyc % 256, wrap edge when cyc becomes a multiple of 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < NCH*NLED; i++) on_cnt[i] = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NCH*NLED; i++) on_cnt[i] += int'(bus.led[i]);
        end
    endtask

    task automatic check_leds(input string tag, input int c, input int d0, input int d1, input int d2);
        check_val($sformatf("%s_ch%0d_led0", tag, c), on_cnt[c*NLED+0], d0);
        check_val($sformatf("%s_ch%0d_led1", tag, c), on_cnt[c*NLED+1], d1);
        check_val($sformatf("%s_ch%0d_led2", tag, c), on_cnt[c*NLED+2], d2);
    endtask

    // 16-cycle bit slots, frames left-aligned (bit 47 first). Also checks each dout
    // against the driven stream delayed by 3 once that channel has consumed 24 bits.
    task automatic send(input logic [47:0] f0, input int nb0, input logic [47:0] f1, input int nb1,
                        input int w1, input int w0, input bit glitch, input int tail);
        logic [47:0]    fr [NCH];
        int             nb [NCH];
        int             fstart [NCH];
        int             nbmax, total, bi, t, w;
        logic [NCH-1:0] v;
        logic           expd;
        fr[0] = f0; fr[1] = f1; nb[0] = nb0; nb[1] = nb1;
        nbmax = (nb0 > nb1) ? nb0 : nb1;
        total = nbmax * 16 + tail;
        for (int c = 0; c < NCH; c++) begin
            fwd_err[c] = 0;
            fstart[c]  = (nb[c] >= 24) ? 16*23 + (fr[c][24] ? w1 : w0) + 3 : total;
        end
        for (int j = 0; j < total; j++) begin
            for (int c = 0; c < NCH; c++) begin
                expd = (j >= fstart[c]) ? hist[j-3][c] : 1'b0;
                if (bus.dout[c] !== expd) fwd_err[c]++;
            end
            v  = '0;
            bi = j / 16;
            t  = j % 16;
            for (int c = 0; c < NCH; c++) begin
                if (bi < nb[c]) begin
                    w    = fr[c][47-bi] ? w1 : w0;
                    v[c] = (t < w) || (glitch && t == 14);
                end
            end
            hist[j] = v;
            bus.din = v;
            @(negedge clk);
        end
    endtask

    initial begin
        int nz_led, nz_dout, ks, sum;
        rst_n   = 1'b1;
        bus.din = '0;
        #2 rst_n = 1'b0;

        // Reset held while din toggles
        nz_led = 0; nz_dout = 0;
        for (int i = 0; i < 20; i++) begin
            bus.din = NCH'(i);
            @(negedge clk);
            if (bus.led != '0)  nz_led++;
            if (bus.dout != '0) nz_dout++;
        end
        check_val("rst_led", nz_led, 0);
        check_val("rst_dout", nz_dout, 0);
        bus.din = '0;
        @(negedge clk);
        rst_n = 1'b1;
        nz_led = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.led != '0 || bus.dout != '0) nz_led++;
        end
        check_val("idle_outputs", nz_led, 0);

        // Single frame on ch0
        send(48'hFF8000_000000, 24, 48'h0, 0, 12, 4, 1'b0, 70);
        check_val("t2_dout0", fwd_err[0], 0);
        check_val("t2_dout1", fwd_err[1], 0);
        repeat (260) @(negedge clk);
        measure(256);
        check_leds("t2", 0, 255, 128, 0);
        check_leds("t2", 1, 0, 0, 0);

        // 48 bits: first 24 kept, rest forwarded
        send(48'h123456_AA55C3, 48, 48'h0, 0, 12, 4, 1'b0, 70);
        check_val("t3_fwd0", fwd_err[0], 0);
        repeat (260) @(negedge clk);
        measure(256);
        check_leds("t3", 0, 18, 52, 86);

        // Partial frame leaves duty alone, next full frame decodes
        send(48'hABC000_000000, 10, 48'h0, 0, 12, 4, 1'b0, 70);
        repeat (260) @(negedge clk);
        measure(256);
        check_leds("t4_partial", 0, 18, 52, 86);
        send(48'h01FE7F_000000, 24, 48'h0, 0, 12, 4, 1'b0, 70);
        repeat (260) @(negedge clk);
        measure(256);
        check_leds("t4_full", 0, 1, 254, 127);

        // Glitches between bits, then threshold-width pulses
        send(48'hFF8000_000000, 24, 48'h0, 0, 12, 4, 1'b1, 70);
        check_val("t5_fwd0", fwd_err[0], 0);
        repeat (260) @(negedge clk);
        measure(256);
        check_leds("t5_glitch", 0, 255, 128, 0);
        send(48'h3CA50F_000000, 24, 48'h0, 0, 8, 2, 1'b0, 70);
        repeat (260) @(negedge clk);
        measure(256);
        check_leds("t5_thresh", 0, 60, 165, 15);

        // ch0 timeout lands on the wrap edge: last fall (bit 23 is '0', 4 high) + 3 + 64
        while (cyc % 256 != (256 - (16*23 + 4 + 67) % 256) % 256) @(negedge clk);
        ks = cyc;
        send(48'h102040_000000, 24, 48'h050607_000000, 24, 12, 4, 1'b0, 0);
        while (cyc < ks + 16*23 + 4 + 67) @(negedge clk);
        measure(256);
        check_leds("t6_old", 0, 60, 165, 15);
        check_leds("t6_old", 1, 0, 0, 0);
        measure(256);
        check_leds("t6_new", 0, 16, 32, 64);
        check_leds("t6_new", 1, 5, 6, 7);

        // Reset in the middle of a frame
        send(48'hFFFFFF_000000, 12, 48'hFFFFFF_000000, 12, 12, 4, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_led", int'(bus.led), 0);
        check_val("t6_rst_dout", int'(bus.dout), 0);
        bus.din = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        measure(256);
        sum = 0;
        for (int i = 0; i < NCH*NLED; i++) sum += on_cnt[i];
        check_val("t6_post_rst_led", sum, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
